nibble_deserializer: RTL
========================

Name: nibble_deserializer

Overview:
Serial-to-parallel front end for the 4-bit load-enable register stage. It collects WIDTH framed serial bits into a word, presents the word on D_out, and pulses load for one cycle. D_out and load connect directly to the register's D and enable inputs. The block also flags framing errors, meaning a new frame that starts before the current word is complete.

Parameters:
WIDTH, 4, bits per word; legal range 2..16.
MSB_FIRST, 1, 1 = first serial bit lands in D_out[WIDTH-1]; 0 = first bit lands in D_out[0].

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
sin  input  1  serial data bit; sampled only when sin_valid=1.
sin_valid  input  1  qualifies sin in the current cycle; may have arbitrary gaps.
frame  input  1  marks the first bit of a word; meaningful only when sin_valid=1.
D_out  output  WIDTH  last completed word; holds between loads.
load  output  1  one-cycle pulse when D_out is updated; drives the register's enable.
busy  output  1  high while a word is partially received.
frame_err  output  1  one-cycle pulse on an aborted word.

Behaviour:
- Reset (reset=0, async): state=IDLE, bit count=0, shift reg=0, D_out=0, load=0, frame_err=0, busy=0. Outputs hold these values until the first clk edge after release.
- States: IDLE, SHIFT. busy = (state==SHIFT), decoded from the state register.
- IDLE:
  - sin_valid & frame: capture sin as bit 0; count=1; go to SHIFT.
  - sin_valid & !frame: stray bit; ignored with no state change and no error.
- SHIFT, sin_valid & !frame:
  - Shift sin in. MSB_FIRST=1: sreg <= {sreg[W-2:0], sin}. MSB_FIRST=0: sreg <= {sin, sreg[W-1:1]}.
  - count++.
  - If this is bit WIDTH, load the full word into D_out, assert load next cycle, go to IDLE, count=0.
- SHIFT, sin_valid & frame (early restart): pulse frame_err for one cycle; discard partial word; capture sin as new bit 0; count=1; stay in SHIFT. D_out and load are unaffected.
- SHIFT, !sin_valid: hold all state (gaps allowed, no timeout).
- Latency: load=1 and the new D_out both appear in the cycle after the edge that sampled the last bit. load is registered and never asserted for two consecutive cycles.
- D_out changes only together with load=1. A downstream register enabled by load captures exactly the completed word.
- Back-to-back frames: a frame bit in the cycle where load=1 is accepted, because state is already IDLE. Zero dead cycles between words.
- Reset mid-word: partial word lost, D_out cleared to 0, no load or frame_err pulse on exit from reset.
- Count width: clog2(WIDTH+1) bits; never wraps, because it returns to 0 on completion.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT};
  - default WIDTH constant (4);
  - count-width function (clog2).
- No sub-module; the shift register and counter are small enough to stay inline.

Test Plan (WIDTH=4 unless stated):
1. MSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, frame with first -> load pulses 1 cycle after 4th bit, D_out=4'b1011, frame_err stays 0.
2. MSB_FIRST=0, same bits with 2-cycle sin_valid gaps between bits -> D_out=4'b1101, single load pulse, busy high from the cycle after bit 1 through the cycle sampling bit 4.
3. Framing error: bits 1,0, then frame with 0,1,1,0 (MSB_FIRST=1) -> frame_err one pulse at the 3rd sampled bit, then D_out=4'b0110 with one load pulse.
4. Back-to-back words 4'hA then 4'h5, no idle cycles, second frame bit coinciding with first load -> two load pulses 4 cycles apart, D_out=A then 5.
5. Reset asserted after 2 bits of a word, released, then full word 4'b0011 -> D_out=0 during and after reset, no pulses, then D_out=4'b0011 with one load.
6. Stray bits (sin_valid=1, frame=0) while IDLE, then a valid word 4'hF -> stray bits ignored, busy=0 until frame, D_out=4'hF.

Source files
------------

// File: rtl/nibble_deserializer_pkg.sv
// Shared types and constants for the nibble deserializer: FSM state encoding,
// default word width and the bit-counter width helper.
package nibble_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter must represent values 0..w, so it needs clog2(w+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end: gathers WIDTH framed serial bits, presents the
// finished word on D_out with a one-cycle load strobe, and flags early restarts.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] D_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  // Only the WIDTH-1 bits that survive the next shift are stored; the bit that
  // would fall off the end is never needed.
  logic [WIDTH-2:0] r_part;
  logic [WIDTH-2:0] w_part_next;
  logic [WIDTH-2:0] w_part_base;
  logic [WIDTH-2:0] w_part_shift;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_next;
  logic             r_load;
  logic             w_load_next;
  logic             r_frame_err;
  logic             w_frame_err_next;

  // A frame bit always starts from an empty register, so the first bit lands
  // in the position that ends up at D_out[WIDTH-1] (or D_out[0]).
  assign w_part_base = (r_state == IDLE || frame) ? '0 : r_part;

  if (MSB_FIRST) begin : g_msb_first
    assign w_word       = {w_part_base, sin};
    assign w_part_shift = w_word[WIDTH-2:0];
  end else begin : g_lsb_first
    assign w_word       = {sin, w_part_base};
    assign w_part_shift = w_word[WIDTH-1:1];
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state     = r_state;
    w_count_next     = r_count;
    w_part_next      = r_part;
    w_dout_next      = r_dout;
    w_load_next      = 1'b0;
    w_frame_err_next = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (sin_valid && frame) begin
          w_part_next  = w_part_shift;
          w_count_next = CW'(1);
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          if (frame) begin
            w_frame_err_next = 1'b1;
            w_part_next      = w_part_shift;
            w_count_next     = CW'(1);
          end else if (r_count == CW'(WIDTH - 1)) begin
            w_dout_next  = w_word;
            w_load_next  = 1'b1;
            w_count_next = '0;
            w_next_state = IDLE;
          end else begin
            w_part_next  = w_part_shift;
            w_count_next = r_count + CW'(1);
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_part      <= '0;
      r_dout      <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_count_next;
      r_part      <= w_part_next;
      r_dout      <= w_dout_next;
      r_load      <= w_load_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign D_out     = r_dout;
  assign load      = r_load;
  assign busy      = (r_state == SHIFT);
  assign frame_err = r_frame_err;

endmodule
